// File: rtl/fp_norm_pack.sv
// fp_norm_pack: normalise, round and pack the FP add/sub mantissa result
// into an IEEE-754 single-precision word, one operation at a time.
module fp_norm_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FRAC_W+1:0]   mag,
  input  logic                sign_in,
  input  logic [EXP_W-1:0]    exp_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP_W+FRAC_W:0] result
);

  localparam int MW = FRAC_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [MW-1:0]       mag_q, mag_n;
  logic [XW-1:0]       exp_q, exp_n;
  logic                sign_q, sign_n;
  logic [EXP_W+FRAC_W:0] res_q, res_n;
  logic                vld_q, vld_n;

  // carry path: shift right once, round to nearest even on the lost bit
  logic [MW-1:0]       m_sh, m_rnd, m_fin;
  logic [XW-1:0]       e_inc, e_fin;
  logic                guard;

  always_comb begin
    m_sh  = {1'b0, mag_q[MW-1:1]};
    guard = mag_q[0];
    e_inc = exp_q + XW'(1);
    m_rnd = m_sh + MW'(guard & m_sh[0]);
    m_fin = m_rnd;
    e_fin = e_inc;
    if (m_rnd[MW-1]) begin
      m_fin = {1'b0, m_rnd[MW-1:1]};
      e_fin = e_inc + XW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = vld_q;
  assign result    = res_q;

  always_comb begin
    state_n = state;
    mag_n   = mag_q;
    exp_n   = exp_q;
    sign_n  = sign_q;
    res_n   = res_q;
    vld_n   = vld_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          mag_n   = mag;
          exp_n   = XW'(exp_in);
          sign_n  = sign_in;
          state_n = NORM;
        end
      end
      NORM: begin
        state_n = DONE;
        if (mag_q == '0) begin
          res_n = '0;
        end else if (mag_q[MW-1]) begin
          if (e_fin >= EMAX)
            res_n = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          else
            res_n = {sign_q, e_fin[EXP_W-1:0], m_fin[FRAC_W-1:0]};
        end else if (mag_q[FRAC_W]) begin
          res_n = {sign_q, exp_q[EXP_W-1:0], mag_q[FRAC_W-1:0]};
        end else if (exp_q <= XW'(1)) begin
          res_n = {sign_q, {EXP_W{1'b0}}, mag_q[FRAC_W-1:0]};
        end else begin
          mag_n   = {mag_q[MW-2:0], 1'b0};
          exp_n   = exp_q - XW'(1);
          state_n = NORM;
        end
      end
      DONE: begin
        // valid rises one cycle after entry; drops on the handshake
        if (!vld_q) begin
          vld_n = 1'b1;
        end else if (out_ready) begin
          vld_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mag_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      res_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mag_q  <= mag_n;
      exp_q  <= exp_n;
      sign_q <= sign_n;
      res_q  <= res_n;
      vld_q  <= vld_n;
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed testbench for fp_norm_pack: hand-computed packed results,
// latencies, backpressure and reset behaviour.
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mag;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int lat;

  fp_norm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic apply(input logic [24:0] m, input logic [7:0] e,
                       input logic s);
    mag      = m;
    exp_in   = e;
    sign_in  = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mag = '0;
    sign_in = 1'b0;
    exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;

    // already normalised, with in_ready low right after acceptance
    mag = 25'h0800000; exp_in = 8'd127; sign_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("norm_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("norm_lat", lat, 32'd2);
    chk("norm_res", result, 32'h3F800000);
    chk("norm_busy2", {31'd0, in_ready}, 32'd0);
    handshake("norm");

    apply(25'h1000003, 8'd127, 1'b0);
    chk("rnd_up_lat", lat, 32'd2);
    chk("rnd_up_res", result, 32'h40000002);
    handshake("rnd_up");

    apply(25'h1000001, 8'd127, 1'b0);
    chk("tie_even_res", result, 32'h40000000);
    handshake("tie_even");

    apply(25'h0000001, 8'd127, 1'b1);
    chk("long_lat", lat, 32'd25);
    chk("long_res", result, 32'hB4000000);
    handshake("long");

    apply(25'h0000100, 8'd5, 1'b0);
    chk("denorm_lat", lat, 32'd6);
    chk("denorm_res", result, 32'h00001000);
    handshake("denorm");

    apply(25'h0000100, 8'd0, 1'b0);
    chk("exp0_lat", lat, 32'd2);
    chk("exp0_res", result, 32'h00000100);
    handshake("exp0");

    apply(25'h0000000, 8'd90, 1'b1);
    chk("zero_lat", lat, 32'd2);
    chk("zero_res", result, 32'h00000000);
    handshake("zero");

    // rounding carries out again and the exponent saturates to infinity
    apply(25'h1FFFFFF, 8'd254, 1'b0);
    chk("ovf_res", result, 32'h7F800000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_res", result, 32'h7F800000);
      chk("bp_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    handshake("ovf");

    // reset in the middle of a long left shift
    mag = 25'h0000001; exp_in = 8'd127; sign_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_res", result, 32'h0);

    apply(25'h0C00000, 8'd128, 1'b1);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_res", result, 32'hC0400000);

    // reset while holding an unaccepted result
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("hold_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("hold_rst_res", result, 32'h0);
    chk("hold_rst_rdy", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
